// File: rtl/fir_decim_buffer.sv
// Post-filter stage: drops FIR warm-up outputs, decimates by DECIM and buffers kept
// samples in a first-word-fall-through FIFO behind a valid/ready stream.
module fir_decim_buffer #(
    parameter int DATA_W     = 16,
    parameter int DECIM      = 4,
    parameter int FIR_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    input  logic [DATA_W-1:0]             filter_out,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int WW = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;

    logic                en_d;
    logic                warm;
    logic [WW-1:0]       warm_cnt;
    logic [PW-1:0]       phase;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [CW-1:0]       count;

    logic                kept;
    logic                push;
    logic                pop;
    logic                full;
    logic                push_ok;
    logic [CW-1:0]       count_next;
    logic [AW-1:0]       rd_next;
    logic                head_load;
    logic [DATA_W-1:0]   head_src;

    // A capture is kept once FIR_LAT-1 captures have been discarded since reset.
    assign kept       = warm || (warm_cnt == WW'(FIR_LAT - 1));
    assign push       = en_d && kept && (phase == '0);
    assign m_valid    = (count != '0);
    assign pop        = m_valid && m_ready;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign push_ok    = push && (!full || pop);
    assign count_next = count + CW'(push_ok) - CW'(pop);
    assign rd_next    = rd_ptr + AW'(pop);
    assign fill_level = count;

    // The head register follows the FIFO front and keeps the last popped word when empty.
    always_comb begin
        head_load = 1'b0;
        head_src  = filter_out;
        if (count_next != '0) begin
            if ((count == '0) || (pop && (count == CW'(1)))) begin
                head_load = 1'b1;
                head_src  = filter_out;
            end else if (pop) begin
                head_load = 1'b1;
                head_src  = mem[rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_d     <= 1'b0;
            warm     <= 1'b0;
            warm_cnt <= '0;
            phase    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            m_data   <= '0;
        end else begin
            en_d <= clk_en;
            if (en_d && !warm) begin
                if (warm_cnt == WW'(FIR_LAT - 1)) begin
                    warm <= 1'b1;
                end else begin
                    warm_cnt <= warm_cnt + WW'(1);
                end
            end
            if (en_d && kept) begin
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (head_load) begin
                m_data <= head_src;
            end
        end
    end

    // Storage carries data only and is not reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= filter_out;
        end
    end

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Bench for fir_decim_buffer: vector table, directed corner sequences and a random run
// against a queue-based reference model; a DECIM=1 instance covers the continuous strobe.
module tb_fir_decim_buffer;

    localparam int FL    = 3;
    localparam int DEC   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clk_en, m_ready, m_valid, overflow;
    logic [15:0] filter_out, m_data;
    logic [3:0]  fill_level;

    logic        rst1 = 1'b1, en1 = 1'b0, rdy1 = 1'b0, valid1, ovf1;
    logic [15:0] fo1 = '0, data1;
    logic [3:0]  fill1;

    fir_decim_buffer #(.DATA_W(16), .DECIM(DEC), .FIR_LAT(FL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .filter_out(filter_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .fill_level(fill_level), .overflow(overflow));

    fir_decim_buffer #(.DATA_W(16), .DECIM(1), .FIR_LAT(FL), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst1), .clk_en(en1), .filter_out(fo1),
        .m_data(data1), .m_valid(valid1), .m_ready(rdy1),
        .fill_level(fill1), .overflow(ovf1));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: capture index, sample queue, sticky overflow, shown head word.
    bit          md_en;
    int          mc;
    logic [15:0] mq[$];
    bit          movf;
    logic [15:0] mhead;
    logic [15:0] pushlog[$];
    logic [15:0] pops[$];

    task automatic model_step(input bit r, input bit e, input logic [15:0] f, input bit rdy);
        bit          pop, push;
        logic [15:0] popped;
        if (r) begin
            md_en = 0; mc = 0; mq.delete(); movf = 0; mhead = '0; pushlog.delete();
        end else begin
            pop  = (mq.size() != 0) && rdy;
            push = 0;
            if (md_en) begin
                mc++;
                push = (mc >= FL) && (((mc - FL) % DEC) == 0);
            end
            popped = mhead;
            if (pop) popped = mq.pop_front();
            if (push) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(f);
                    pushlog.push_back(f);
                end else begin
                    movf = 1;
                end
            end
            if (mq.size() != 0) mhead = mq[0];
            else if (pop) mhead = popped;
            md_en = e;
        end
    endtask

    task automatic tick(input bit r, input bit e, input logic [15:0] f, input bit rdy, input bit chk);
        rst = r; clk_en = e; filter_out = f; m_ready = rdy;
        if (!r && m_valid && rdy) pops.push_back(m_data);
        @(posedge clk);
        model_step(r, e, f, rdy);
        #1;
        if (chk) begin
            check("m_valid", m_valid, mq.size() != 0);
            check("m_data", m_data, mhead);
            check("fill_level", fill_level, mq.size());
            check("overflow", overflow, movf);
        end
    endtask

    task automatic tick1(input bit r, input bit e, input logic [15:0] f, input bit rdy);
        rst1 = r; en1 = e; fo1 = f; rdy1 = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd16();
        logic [31:0] v;
        v = $urandom;
        return v[15:0];
    endfunction

    typedef struct {
        bit          r;
        bit          e;
        logic [15:0] f;
        bit          rdy;
        bit          ev;
        logic [15:0] ed;
        int          ef;
        bit          eo;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1, 0, 16'd0,  0, 0, 16'd0,  0, 0};
        tbl[1]  = '{1, 0, 16'd0,  0, 0, 16'd0,  0, 0};
        tbl[2]  = '{0, 1, 16'd0,  0, 0, 16'd0,  0, 0};
        tbl[3]  = '{0, 1, 16'd10, 0, 0, 16'd0,  0, 0};
        tbl[4]  = '{0, 1, 16'd20, 0, 0, 16'd0,  0, 0};
        tbl[5]  = '{0, 1, 16'd30, 0, 1, 16'd30, 1, 0};
        tbl[6]  = '{0, 1, 16'd40, 0, 1, 16'd30, 1, 0};
        tbl[7]  = '{0, 1, 16'd50, 0, 1, 16'd30, 1, 0};
        tbl[8]  = '{0, 1, 16'd60, 0, 1, 16'd30, 1, 0};
        tbl[9]  = '{0, 1, 16'd70, 0, 1, 16'd30, 2, 0};
        tbl[10] = '{0, 0, 16'd80, 1, 1, 16'd70, 1, 0};
        tbl[11] = '{0, 0, 16'd90, 1, 0, 16'd70, 0, 0};
        tbl[12] = '{0, 0, 16'd0,  1, 0, 16'd70, 0, 0};
        tbl[13] = '{1, 0, 16'd0,  1, 0, 16'd0,  0, 0};

        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].r, tbl[i].e, tbl[i].f, tbl[i].rdy, 1'b0);
            check($sformatf("tbl%0d_valid", i), m_valid, tbl[i].ev);
            check($sformatf("tbl%0d_data", i), m_data, tbl[i].ed);
            check($sformatf("tbl%0d_fill", i), fill_level, tbl[i].ef);
            check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].eo);
        end

        // Warm-up and decimation with a strobe every 4th cycle, filter_out = capture index.
        begin
            logic [15:0] fo_prev;
            fo_prev = '0;
            tick(1, 0, 0, 1, 1);
            tick(1, 0, 0, 1, 1);
            pops.delete();
            for (int k = 1; k <= 16; k++) begin
                tick(0, 1, fo_prev, 1, 1);
                for (int j = 0; j < 3; j++) tick(0, 0, 16'(k), 1, 1);
                fo_prev = 16'(k);
            end
            tick(0, 0, fo_prev, 1, 1);
            check("dec_count", pops.size(), 4);
            for (int i = 0; i < 4; i++)
                check("dec_seq", (i < pops.size()) ? pops[i] : 16'hFFFF, 3 + 4 * i);
        end

        // Back-pressure: nine decimated pushes into an 8-deep FIFO, then drain.
        tick(1, 0, 0, 0, 1);
        for (int i = 0; i < 36; i++) tick(0, 1, rnd16(), 0, 1);
        check("bp_fill", fill_level, 8);
        check("bp_ovf", overflow, 1);
        pops.delete();
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, 1);
        check("bp_drain_count", pops.size(), 8);
        for (int i = 0; i < 8; i++)
            check("bp_order", (i < pops.size() && i < pushlog.size()) ? pops[i] : 16'hFFFF,
                  (i < pushlog.size()) ? pushlog[i] : 16'h0);
        check("bp_ovf_sticky", overflow, 1);

        // Full FIFO with push and pop on the same edge.
        tick(1, 0, 0, 0, 1);
        for (int i = 0; i < 100 && mq.size() < DEPTH; i++) tick(0, 1, rnd16(), 0, 1);
        check("full_reached", fill_level, 8);
        pops.delete();
        for (int i = 0; i < 20; i++) begin
            bit wp;
            wp = md_en && ((mc + 1) >= FL) && (((mc + 1 - FL) % DEC) == 0);
            tick(0, 1, rnd16(), wp, 1);
            if (wp) check("full_pp_fill", fill_level, 8);
        end
        check("full_pp_ovf", overflow, 0);
        for (int i = 0; i < pops.size(); i++)
            check("full_pp_order", pops[i], (i < pushlog.size()) ? pushlog[i] : 16'h0);

        // Reset mid-stream with three buffered samples.
        tick(1, 0, 0, 0, 1);
        for (int i = 0; i < 60 && mq.size() < 3; i++) tick(0, 1, rnd16(), 0, 1);
        check("mid_fill_pre", fill_level, 3);
        tick(1, 0, 0, 0, 1);
        check("mid_fill", fill_level, 0);
        check("mid_ovf", overflow, 0);
        tick(0, 1, 0, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            tick(0, 1, 16'(500 + k), 0, 1);
            if (k == 2) check("mid_no_early", m_valid, 0);
        end
        check("mid_first_valid", m_valid, 1);
        check("mid_first_data", m_data, 503);

        // Random traffic with occasional resets.
        tick(1, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            bit r, e, rdy;
            r   = ($urandom_range(0, 99) == 0);
            e   = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            tick(r, e, rnd16(), rdy, 1);
        end

        // Continuous strobe on the DECIM=1 instance.
        begin
            bit          m1en;
            int          c1;
            logic [15:0] f;
            m1en = 0;
            c1   = 0;
            tick1(1, 0, 0, 1);
            tick1(1, 0, 0, 1);
            check("d1_rst_valid", valid1, 0);
            check("d1_rst_data", data1, 0);
            check("d1_rst_fill", fill1, 0);
            check("d1_rst_ovf", ovf1, 0);
            for (int i = 0; i < 20; i++) begin
                bit cap;
                f   = rnd16();
                cap = m1en;
                tick1(0, 1, f, 1);
                if (cap) c1++;
                m1en = 1;
                if (cap && c1 >= FL) begin
                    check("d1_valid", valid1, 1);
                    check("d1_data", data1, f);
                end else begin
                    check("d1_warm_valid", valid1, 0);
                end
                check("d1_fill_le1", fill1 <= 4'd1, 1);
                check("d1_ovf", ovf1, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
